// File: rtl/exc_scheduler_pkg.sv
// Shared constants for the exception/interrupt scheduler.
// Holds the ExcCode values, the scheduler FSM state encoding and the
// default trap handler entry address.
package exc_scheduler_pkg;

    // ExcCode values written to Cause[6:2]
    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    // Default trap handler entry PC
    localparam logic [31:0] DEFAULT_HANDLER_ADDR = 32'h0000_4180;

    // Scheduler states: RUN accepts events, BLANK holds flush after one
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_BLANK = 1'b1
    } sched_state_e;

endpackage

// File: rtl/exc_scheduler_int_sync.sv
// int_sync: W-wide two-flop synchronizer for asynchronous level interrupts.
// Ports:
//   clk    in  1  clock
//   reset  in  1  synchronous, active-high; clears both flop stages
//   d_i    in  W  asynchronous input lines
//   q_o    out W  synchronized lines (second flop stage)
module int_sync #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Two-stage synchronizer chain
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/exc_scheduler.sv
// exc_scheduler: sequences the CP0 register block for traps and ERET.
// Each cycle in RUN it picks at most one event (interrupt > exception > ERET),
// pulses the CP0 strobes, flushes the pipeline and redirects the PC, then
// spends BLANK_CYCLES cycles in BLANK with flush held and new events blocked.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   hw_int                     asynchronous interrupt levels (synchronized here)
//   cp0_ie/cp0_exl/cp0_im      SR.IE, SR.EXL, SR.IM
//   cp0_epc                    current EPC, ERET target
//   m_valid/m_exccode/m_vpc    M-stage valid, exception code, PC
//   m_bd/m_eret                M-stage delay-slot flag and ERET flag
//   take/take_code/take_epc/take_bd   CP0 trap write strobe and payload
//   exl_clr                    CP0 EXL clear strobe (ERET)
//   ip                         synchronized pending lines for Cause.IP
//   flush/redirect/redirect_pc pipeline kill and PC redirect
//   trap_count                 saturating count of takes (debug)
module exc_scheduler
    import exc_scheduler_pkg::*;
#(
    parameter int          HW_INT_W     = 6,
    parameter logic [31:0] HANDLER_ADDR = DEFAULT_HANDLER_ADDR,
    parameter int          BLANK_CYCLES = 1,
    parameter int          TRAP_CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [HW_INT_W-1:0]   hw_int,
    input  logic                  cp0_ie,
    input  logic                  cp0_exl,
    input  logic [HW_INT_W-1:0]   cp0_im,
    input  logic [31:0]           cp0_epc,
    input  logic                  m_valid,
    input  logic [4:0]            m_exccode,
    input  logic [31:0]           m_vpc,
    input  logic                  m_bd,
    input  logic                  m_eret,
    output logic                  take,
    output logic [4:0]            take_code,
    output logic [31:0]           take_epc,
    output logic                  take_bd,
    output logic                  exl_clr,
    output logic [HW_INT_W-1:0]   ip,
    output logic                  flush,
    output logic                  redirect,
    output logic [31:0]           redirect_pc,
    output logic [TRAP_CNT_W-1:0] trap_count
);

    localparam logic [2:0]            BLANK_LOAD = 3'(BLANK_CYCLES);
    localparam logic [TRAP_CNT_W-1:0] TRAP_MAX   = '1;

    sched_state_e          state_q, state_d;
    logic [2:0]            blank_cnt_q, blank_cnt_d;
    logic [TRAP_CNT_W-1:0] trap_count_q;
    logic [HW_INT_W-1:0]   ip_s;

    logic int_ok_s;
    logic exc_ok_s;
    logic eret_ok_s;

    int_sync #(
        .W (HW_INT_W)
    ) u_int_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (hw_int),
        .q_o   (ip_s)
    );

    assign ip = ip_s;

    // Event qualification; interrupts wait for a real instruction in M so EPC is meaningful
    always_comb begin
        int_ok_s  = (|(ip_s & cp0_im)) & cp0_ie & ~cp0_exl & m_valid;
        exc_ok_s  = m_valid & (m_exccode != 5'd0) & ~cp0_exl;
        eret_ok_s = m_valid & m_eret & ~int_ok_s & ~exc_ok_s;
    end

    // Next-state, blank counter and event outputs; reset gates outputs so a pending take is dropped
    always_comb begin
        state_d     = state_q;
        blank_cnt_d = blank_cnt_q;
        take        = 1'b0;
        take_code   = 5'd0;
        take_epc    = 32'd0;
        take_bd     = 1'b0;
        exl_clr     = 1'b0;
        flush       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        if (reset) begin
            state_d     = ST_RUN;
            blank_cnt_d = 3'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (int_ok_s || exc_ok_s) begin
                        take        = 1'b1;
                        take_code   = int_ok_s ? EXC_INT : m_exccode;
                        // Delay-slot traps restart at the branch
                        take_epc    = m_bd ? (m_vpc - 32'd4) : m_vpc;
                        take_bd     = m_bd;
                        flush       = 1'b1;
                        redirect    = 1'b1;
                        redirect_pc = HANDLER_ADDR;
                        state_d     = ST_BLANK;
                        blank_cnt_d = BLANK_LOAD;
                    end else if (eret_ok_s) begin
                        exl_clr     = 1'b1;
                        flush       = 1'b1;
                        redirect    = 1'b1;
                        redirect_pc = cp0_epc;
                        state_d     = ST_BLANK;
                        blank_cnt_d = BLANK_LOAD;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_BLANK: begin
                    flush = 1'b1;
                    if (blank_cnt_q <= 3'd1) begin
                        state_d     = ST_RUN;
                        blank_cnt_d = 3'd0;
                    end else begin
                        blank_cnt_d = blank_cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d     = ST_RUN;
                    blank_cnt_d = 3'd0;
                end
            endcase
        end
    end

    // State and blank counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            blank_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            blank_cnt_q <= blank_cnt_d;
        end
    end

    // Saturating trap counter
    always_ff @(posedge clk) begin
        if (reset) begin
            trap_count_q <= '0;
        end else if (take && (trap_count_q != TRAP_MAX)) begin
            trap_count_q <= trap_count_q + 1'b1;
        end else begin
            trap_count_q <= trap_count_q;
        end
    end

    assign trap_count = trap_count_q;

endmodule

// File: tb/tb_exc_scheduler.sv
// Directed testbench for exc_scheduler. Two instances share the stimulus:
// dut uses the default parameters, dut3 uses BLANK_CYCLES=3 and a 4-bit
// trap counter so saturation is reachable in a short run.
module tb_exc_scheduler;

    logic        clk;
    logic        reset;
    logic [5:0]  hw_int;
    logic        cp0_ie;
    logic        cp0_exl;
    logic [5:0]  cp0_im;
    logic [31:0] cp0_epc;
    logic        m_valid;
    logic [4:0]  m_exccode;
    logic [31:0] m_vpc;
    logic        m_bd;
    logic        m_eret;

    logic        take,  take3;
    logic [4:0]  take_code, take_code3;
    logic [31:0] take_epc, take_epc3;
    logic        take_bd, take_bd3;
    logic        exl_clr, exl_clr3;
    logic [5:0]  ip, ip3;
    logic        flush, flush3;
    logic        redirect, redirect3;
    logic [31:0] redirect_pc, redirect_pc3;
    logic [15:0] trap_count;
    logic [3:0]  trap_count3;

    int n_tests;
    int n_fail;

    exc_scheduler dut (
        .clk (clk), .reset (reset), .hw_int (hw_int), .cp0_ie (cp0_ie),
        .cp0_exl (cp0_exl), .cp0_im (cp0_im), .cp0_epc (cp0_epc),
        .m_valid (m_valid), .m_exccode (m_exccode), .m_vpc (m_vpc),
        .m_bd (m_bd), .m_eret (m_eret), .take (take), .take_code (take_code),
        .take_epc (take_epc), .take_bd (take_bd), .exl_clr (exl_clr),
        .ip (ip), .flush (flush), .redirect (redirect),
        .redirect_pc (redirect_pc), .trap_count (trap_count)
    );

    exc_scheduler #(
        .BLANK_CYCLES (3),
        .TRAP_CNT_W   (4)
    ) dut3 (
        .clk (clk), .reset (reset), .hw_int (hw_int), .cp0_ie (cp0_ie),
        .cp0_exl (cp0_exl), .cp0_im (cp0_im), .cp0_epc (cp0_epc),
        .m_valid (m_valid), .m_exccode (m_exccode), .m_vpc (m_vpc),
        .m_bd (m_bd), .m_eret (m_eret), .take (take3), .take_code (take_code3),
        .take_epc (take_epc3), .take_bd (take_bd3), .exl_clr (exl_clr3),
        .ip (ip3), .flush (flush3), .redirect (redirect3),
        .redirect_pc (redirect_pc3), .trap_count (trap_count3)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value with its expected value
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change
    task automatic settle();
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        hw_int    = 6'h00;
        cp0_ie    = 1'b0;
        cp0_exl   = 1'b0;
        cp0_im    = 6'h00;
        cp0_epc   = 32'h0;
        m_valid   = 1'b0;
        m_exccode = 5'd0;
        m_vpc     = 32'h0;
        m_bd      = 1'b0;
        m_eret    = 1'b0;
        idle(2);
        reset = 1'b0;
        settle();
        // Reset state
        chk("rst_take", {31'd0, take}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_rpc", redirect_pc, 32'd0);
        chk("rst_cnt", {16'd0, trap_count}, 32'd0);

        // 1. Synchronizer latency: hw_int[0] rises at cycle 0
        cp0_im = 6'h01; cp0_ie = 1'b1; m_valid = 1'b1; m_vpc = 32'h0000_2000;
        hw_int = 6'h01;
        settle();
        chk("t1_ip_c0", {26'd0, ip}, 32'd0);
        chk("t1_take_c0", {31'd0, take}, 32'd0);
        step(); settle();
        chk("t1_ip_c1", {26'd0, ip}, 32'd0);
        chk("t1_take_c1", {31'd0, take}, 32'd0);
        step(); settle();
        chk("t1_ip_c2", {26'd0, ip}, 32'd1);
        chk("t1_take_c2", {31'd0, take}, 32'd1);
        chk("t1_code", {27'd0, take_code}, 32'd0);
        chk("t1_rpc", redirect_pc, 32'h0000_4180);
        chk("t1_flush_c2", {31'd0, flush}, 32'd1);
        step();
        cp0_exl = 1'b1; hw_int = 6'h00;
        settle();
        chk("t1_take_c3", {31'd0, take}, 32'd0);
        chk("t1_flush_c3", {31'd0, flush}, 32'd1);
        chk("t1_redir_c3", {31'd0, redirect}, 32'd0);
        step(); settle();
        chk("t1_flush_c4", {31'd0, flush}, 32'd0);
        idle(4);

        // 2. Overflow in a delay slot
        cp0_ie = 1'b0; cp0_exl = 1'b0; m_valid = 1'b1;
        m_exccode = 5'd12; m_vpc = 32'h0000_3010; m_bd = 1'b1;
        settle();
        chk("t2_take", {31'd0, take}, 32'd1);
        chk("t2_epc", take_epc, 32'h0000_300C);
        chk("t2_bd", {31'd0, take_bd}, 32'd1);
        chk("t2_code", {27'd0, take_code}, 32'd12);
        chk("t2_redir", {31'd0, redirect}, 32'd1);
        step();
        cp0_exl = 1'b1;
        settle();
        chk("t2_take_blank", {31'd0, take}, 32'd0);
        chk("t2_flush_blank", {31'd0, flush}, 32'd1);
        step(); settle();
        chk("t2_flush_run", {31'd0, flush}, 32'd0);
        chk("t2_epc_idle", take_epc, 32'd0);
        chk("t2_rpc_idle", redirect_pc, 32'd0);
        m_valid = 1'b0; m_exccode = 5'd0; m_bd = 1'b0;
        idle(4);

        // 3. Interrupt + exception + ERET in the same cycle
        cp0_ie = 1'b1; cp0_im = 6'h01; hw_int = 6'h01;
        idle(3);
        cp0_exl = 1'b0; m_valid = 1'b1; m_exccode = 5'd10; m_eret = 1'b1;
        m_vpc = 32'h0000_5000; cp0_epc = 32'h0000_7777;
        settle();
        chk("t3_take", {31'd0, take}, 32'd1);
        chk("t3_code", {27'd0, take_code}, 32'd0);
        chk("t3_epc", take_epc, 32'h0000_5000);
        chk("t3_exlclr", {31'd0, exl_clr}, 32'd0);
        chk("t3_rpc", redirect_pc, 32'h0000_4180);
        step();
        cp0_exl = 1'b1; m_valid = 1'b0; m_exccode = 5'd0; m_eret = 1'b0;
        hw_int = 6'h00; cp0_ie = 1'b0;
        idle(5);

        // 4. ERET with EXL set, no interrupt
        cp0_epc = 32'h0000_3404; m_valid = 1'b1; m_eret = 1'b1;
        settle();
        chk("t4_exlclr", {31'd0, exl_clr}, 32'd1);
        chk("t4_rpc", redirect_pc, 32'h0000_3404);
        chk("t4_take", {31'd0, take}, 32'd0);
        chk("t4_flush", {31'd0, flush}, 32'd1);
        step();
        m_eret = 1'b0; m_exccode = 5'd8;
        settle();
        chk("t4_exlclr_blank", {31'd0, exl_clr}, 32'd0);
        step(); settle();
        chk("t4_sys_exl_take", {31'd0, take}, 32'd0);
        chk("t4_sys_exl_flush", {31'd0, flush}, 32'd0);
        chk("t4_cnt", {16'd0, trap_count}, 32'd3);
        m_valid = 1'b0; m_exccode = 5'd0;
        idle(5);

        // 5. Bubble deferral and BLANK_CYCLES=3 (dut3)
        cp0_exl = 1'b0; cp0_ie = 1'b1; cp0_im = 6'h01; hw_int = 6'h01;
        idle(2);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t5_bubble_take", {31'd0, take3}, 32'd0);
            step();
        end
        m_valid = 1'b1; m_vpc = 32'h0000_6000;
        settle();
        chk("t5_take", {31'd0, take3}, 32'd1);
        chk("t5_epc", take_epc3, 32'h0000_6000);
        step();
        hw_int = 6'h00; cp0_ie = 1'b0; m_exccode = 5'd4;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t5_blank_take", {31'd0, take3}, 32'd0);
            chk("t5_blank_flush", {31'd0, flush3}, 32'd1);
            step();
        end
        settle();
        chk("t5_run_take", {31'd0, take3}, 32'd1);
        chk("t5_run_code", {27'd0, take_code3}, 32'd4);
        step();
        m_valid = 1'b0; m_exccode = 5'd0;
        idle(3);
        settle();
        chk("t5_gone_take", {31'd0, take3}, 32'd0);
        chk("t5_gone_flush", {31'd0, flush3}, 32'd0);

        // 6. Reset during BLANK, then counter saturation
        m_valid = 1'b1; m_exccode = 5'd12; m_vpc = 32'h0000_3000;
        step();
        reset = 1'b1;
        settle();
        chk("t6_rst_take", {31'd0, take}, 32'd0);
        chk("t6_rst_flush3", {31'd0, flush3}, 32'd0);
        step();
        reset = 1'b0; m_valid = 1'b0; m_exccode = 5'd0;
        settle();
        chk("t6_post_flush3", {31'd0, flush3}, 32'd0);
        chk("t6_post_take", {31'd0, take}, 32'd0);
        chk("t6_post_cnt", {16'd0, trap_count}, 32'd0);
        chk("t6_post_cnt3", {28'd0, trap_count3}, 32'd0);
        chk("t6_post_ip", {26'd0, ip}, 32'd0);
        step();
        m_valid = 1'b1; m_exccode = 5'd12;
        settle();
        chk("t6_first_take", {31'd0, take3}, 32'd1);
        idle(20);
        chk("t6_cnt3_mid", {28'd0, trap_count3}, 32'd5);
        chk("t6_cnt_mid", {16'd0, trap_count}, 32'd10);
        idle(60);
        chk("t6_cnt3_sat", {28'd0, trap_count3}, 32'd15);
        chk("t6_cnt_80", {16'd0, trap_count}, 32'd40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
